// File: rtl/zombie_spawner.sv
// Whack-a-zombie game core: LFSR-placed zombie on one of three LEDs,
// scored against debounced buttons over a fixed number of game ticks.
module zombie_spawner #(
  parameter int         TICK_DIV   = 4,
  parameter int         SHOW_TICKS = 3,
  parameter int         GAP_TICKS  = 1,
  parameter int         GAME_TICKS = 20,
  parameter logic [7:0] SEED       = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       btn3,
  output logic [2:0] led,
  output logic [7:0] score,
  output logic [7:0] misses,
  output logic       hit,
  output logic       gameover
);

  localparam int PW   = $clog2(TICK_DIV);
  localparam int SMAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int SW   = $clog2(SMAX + 1);
  localparam int GW   = $clog2(GAME_TICKS + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SHOW_LAST = SW'(SHOW_TICKS - 1);
  localparam logic [SW-1:0] GAP_LAST  = SW'(GAP_TICKS - 1);
  localparam logic [GW-1:0] GAME_LAST = GW'(GAME_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE, SPAWN, SHOW, GAP, FINISH
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [SW-1:0] sg_cnt, sg_n;
  logic [GW-1:0] game_cnt, game_n;
  logic [7:0]    lfsr, lfsr_n;
  logic [2:0]    hist;
  logic [2:0]    led_n;
  logic [7:0]    score_n, misses_n;
  logic          hit_n, gameover_n;

  logic [2:0] btn, edges;
  logic       running, tick, game_end;
  logic       good, bad, timeout;
  logic [1:0] miss_inc;

  function automatic logic [7:0] sat_add(logic [7:0] a, logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, b};
    return s[8] ? 8'hff : s[7:0];
  endfunction

  function automatic logic [2:0] onehot(logic [1:0] p);
    logic [2:0] r;
    case (p)
      2'd0:    r = 3'b001;
      2'd1:    r = 3'b010;
      2'd2:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  assign btn      = {btn3, btn2, btn1};
  assign edges    = btn & ~hist;
  assign running  = (state == SPAWN) || (state == SHOW) || (state == GAP);
  assign tick     = running && (presc == PRE_LAST);
  assign game_end = tick && (game_cnt == GAME_LAST);
  // led is one-hot, so equality also guarantees a single edge
  assign good     = (edges != 3'b000) && (edges == led);
  assign bad      = (edges != 3'b000) && !good;
  assign timeout  = tick && (sg_cnt == SHOW_LAST);
  assign miss_inc = {1'b0, bad} + {1'b0, timeout};

  always_comb begin
    state_n  = state;
    presc_n  = presc;
    sg_n     = sg_cnt;
    game_n   = game_cnt;
    lfsr_n   = lfsr;
    led_n    = led;
    score_n  = score;
    misses_n = misses;
    hit_n    = 1'b0;

    if (running) begin
      presc_n = tick ? '0 : presc + 1'b1;
      if (tick) game_n = game_cnt + 1'b1;
    end

    unique case (state)
      IDLE, FINISH: begin
        if (start) begin
          state_n  = SPAWN;
          presc_n  = '0;
          sg_n     = '0;
          game_n   = '0;
          score_n  = '0;
          misses_n = '0;
        end
      end
      SPAWN: begin
        lfsr_n  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        led_n   = onehot(lfsr_n[1:0]);
        sg_n    = '0;
        state_n = SHOW;
      end
      SHOW: begin
        if (good) begin
          score_n = sat_add(score, 2'd1);
          hit_n   = 1'b1;
          led_n   = '0;
          sg_n    = '0;
          state_n = GAP;
        end else begin
          misses_n = sat_add(misses, miss_inc);
          if (timeout) begin
            led_n   = '0;
            sg_n    = '0;
            state_n = GAP;
          end else if (tick) begin
            sg_n = sg_cnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (sg_cnt == GAP_LAST) begin
            sg_n    = '0;
            state_n = SPAWN;
          end else begin
            sg_n = sg_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // end of game wins over any in-game transition
    if (game_end) begin
      state_n = FINISH;
      led_n   = '0;
      hit_n   = 1'b0;
    end

    gameover_n = (state_n == FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      presc    <= '0;
      sg_cnt   <= '0;
      game_cnt <= '0;
      lfsr     <= SEED;
      hist     <= '0;
      led      <= '0;
      score    <= '0;
      misses   <= '0;
      hit      <= 1'b0;
      gameover <= 1'b0;
    end else begin
      state    <= state_n;
      presc    <= presc_n;
      sg_cnt   <= sg_n;
      game_cnt <= game_n;
      lfsr     <= lfsr_n;
      hist     <= btn;
      led      <= led_n;
      score    <= score_n;
      misses   <= misses_n;
      hit      <= hit_n;
      gameover <= gameover_n;
    end
  end

endmodule

// File: doc/zombie_spawner.md
ZOMBIE_SPAWNER -- requirements
Module: zombie_spawner

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, meaning clk cycles per game tick (>=2).
REQ-002 SHALL have parameter SHOW_TICKS, default 3, meaning ticks a zombie stays lit before counting as escaped.
REQ-003 SHALL have parameter GAP_TICKS, default 1, meaning ticks all LEDs stay dark between zombies.
REQ-004 SHALL have parameter GAME_TICKS, default 20, meaning game length in ticks.
REQ-005 SHALL have parameter SEED, default 8'h01, meaning the LFSR load value (nonzero).
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-008 SHALL have port start  input  1  level sampled each clk; starts a game from IDLE or FINISH.
REQ-009 SHALL have ports btn1, btn2, btn3  input  1 each  player buttons, already synchronized and debounced, active-high.
REQ-010 SHALL have port led  output  3  registered one-hot zombie position (bit0=btn1 ... bit2=btn3); 0 = none.
REQ-011 SHALL have port score  output  8  registered hit count.
REQ-012 SHALL have port misses  output  8  registered count of wrong presses plus escaped zombies.
REQ-013 SHALL have port hit  output  1  registered one-cycle pulse per correct hit.
REQ-014 SHALL have port gameover  output  1  registered; high only in FINISH.

Function
REQ-015 SHALL implement states IDLE, SPAWN, SHOW, GAP, FINISH.
REQ-016 SHALL detect button press as rising edge: btnN high this cycle and low in the previous sampled cycle (per-button history register).
REQ-017 IDLE/FINISH with start=1 SHALL go to SPAWN and clear score, misses, prescaler, show/gap counter, game tick counter; LFSR is not reloaded.
REQ-018 SPAWN SHALL last one cycle: LFSR steps next={lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; led loads one-hot of pos from the NEW value, pos=lfsr[1:0], with 2'b11 mapped to 0; show counter cleared; next state SHOW.
REQ-019 led SHALL become nonzero exactly two clk edges after the edge that samples start=1.
REQ-020 Prescaler SHALL count 0..TICK_DIV-1 in SPAWN/SHOW/GAP, producing a one-cycle tick on wrap; it SHALL hold at 0 in IDLE/FINISH.
REQ-021 SHOW with exactly one rising edge and it matches led SHALL, on the next edge: score+1 (saturate at 255), hit=1, led=0, enter GAP.
REQ-022 SHOW with a rising edge on a non-lit button, or rising edges on two or more buttons in the same cycle, SHALL increment misses (saturate 255) once; zombie stays lit, state stays SHOW.
REQ-023 SHOW reaching SHOW_TICKS ticks with no hit SHALL increment misses once, set led=0, enter GAP; a correct hit in the same cycle as the timeout counts as a hit, not a miss.
REQ-024 Button edges outside SHOW SHALL be ignored (no count change).
REQ-025 GAP SHALL hold led=0 for GAP_TICKS ticks then enter SPAWN.
REQ-026 Game tick counter SHALL increment per tick in SPAWN/SHOW/GAP; when it reaches GAME_TICKS the next state SHALL be FINISH from any of these states, overriding SHOW/GAP transitions; a hit or miss in that same cycle is still counted.
REQ-027 FINISH SHALL force led=0, hit=0, gameover=1, and hold score/misses until start or rst.
REQ-028 start while in SPAWN/SHOW/GAP SHALL be ignored.

Reset
REQ-029 rst=1 SHALL asynchronously force state IDLE, lfsr=SEED, led=0, score=0, misses=0, hit=0, gameover=0, all counters and button history 0.
REQ-030 rst asserted mid-game SHALL abort immediately; after release the block waits in IDLE for start.

Verification (defaults)
REQ-031 rst pulse, then start=1 one cycle -> SPAWN, lfsr 01->02, led=3'b100 two edges after start sampled.
REQ-032 led=3'b100, btn3 rising edge -> next edge score=1, hit=1 for one cycle, led=0; after 1 tick GAP next SPAWN gives lfsr=04, led=3'b001.
REQ-033 led=3'b001, btn2 press then btn1+btn3 pressed together -> misses=2, led stays 3'b001, score unchanged.
REQ-034 no presses after spawn -> after 3 ticks (12 clks) led=0, misses+1.
REQ-035 let game run -> after 20 ticks (80 clks from start) gameover=1, led=0, counts frozen; further presses no effect; start=1 -> counts cleared, gameover=0, new zombie.
REQ-036 rst asserted mid-SHOW -> same cycle led=0, score=0, gameover=0; state IDLE until start.
